line_clear_ctrl: RTL and testbench
==================================

# line_clear_ctrl

Sequencer that owns the 10x20 board RAM after a piece lands. It scans rows bottom-up for completely filled rows. Each full row is removed by shifting every row above it down by one, and the top row is cleared. The top level routes the board RAM port to this block while `busy` is high, and to the piece writer otherwise. It reports how many lines were cleared.

## Interface
Parameters:
- `BOARD_W`, 10, cells per row (x = 0..BOARD_W-1)
- `BOARD_H`, 20, rows (y = 0 top .. BOARD_H-1 bottom)
- `CELL_W`, 6, bits per cell; value 0 = empty

Ports:
- `clk`  in  1  single clock, all logic on rising edge
- `resetn`  in  1  reset, synchronous, active-low
- `start`  in  1  request a clear pass; sampled only in IDLE
- `ram_addr`  out  8  board address = y*BOARD_W + x
- `ram_wren`  out  1  write strobe, one cycle per written cell
- `ram_data`  out  CELL_W  write data
- `ram_q`  in  CELL_W  read data, valid the cycle after `ram_addr` is presented
- `busy`  out  1  high in every state except IDLE; top level gives this block the RAM port
- `done`  out  1  one-cycle pulse at end of pass
- `lines`  out  3  full rows cleared in the last pass, saturates at 7; held until next `start`

## Operation
- States: IDLE, SCAN_A, SCAN_W, SH_A, SH_W, SH_WR, CLR, DONE.
- IDLE with `start`=1: y<=BOARD_H-1, x<=0, `lines`<=0, next state SCAN_A.
- SCAN_A: drive addr(x,y), wren=0, then go to SCAN_W.
- SCAN_W: evaluate `ram_q`.
  - If the cell is 0 (row not full) and y==0, go to DONE. Otherwise y<=y-1, x<=0, go to SCAN_A.
  - If the cell is nonzero and x<BOARD_W-1: x<=x+1, go to SCAN_A.
  - If the cell is nonzero and x==BOARD_W-1 (row full): `lines`<=sat(lines+1), r<=y, x<=0.
    - y>0: go to SH_A.
    - y==0: go to CLR.
- Shift phase copies row r-1 into row r:
  - SH_A drives addr(x,r-1).
  - SH_W latches `ram_q` into cell register.
  - SH_WR drives addr(x,r), data=cell register, wren=1.
  - Then x+1. After x==BOARD_W-1: r<=r-1, x<=0. When r reaches 0, go to CLR.
- CLR: addr(x,0), data=0, wren=1, one cell per cycle. After x==BOARD_W-1: x<=0, go to SCAN_A with y unchanged, so the shifted-down row is re-scanned.
- DONE: `done`=1 for one cycle, then IDLE.
- Address arithmetic: y*BOARD_W+x, 8-bit, max 199. x and r counters never leave range.

## Timing
- Reset (`resetn`=0 at a rising edge):
  - State IDLE, `ram_wren`=0, `busy`=0, `done`=0, `lines`=0, `ram_addr`=0, `ram_data`=0.
  - Applies mid-pass too. The RAM may then hold a partially shifted board, and the top level must reload it.
- `start` while busy is ignored. `start` during DONE is ignored; it is accepted next cycle in IDLE.
- `ram_wren` is never high outside SH_WR and CLR, and is high for exactly one cycle per written cell.
- Cycle costs:
  - Scan: 2 cycles per cell read. Exit at the first empty cell.
  - Shift: 3 cycles per cell.
  - Clear: 1 cycle per cell.
  - DONE: 1 cycle.
- Timeline: cycle n = the cycle after edge n. `start` is accepted at edge 0 and `busy` rises in cycle 1.
- All outputs are registered or decoded from state; no combinational path from `ram_q` to outputs.

## Structure
- Shared tetris package holds:
  - constants BOARD_W=10, BOARD_H=20, CELL_W=6, ADDR_W=8, EMPTY_CELL=0
  - the state enum for this block
- Address formation reuses the existing `coord_to_addr` sub-module, one instance fed by muxed (x, y/r/r-1/0).
- RAM port mux against the piece writer lives in the top level, selected by `busy`.

## Test plan
- Empty board, `start` pulse → 20 rows x 2 cycles. `busy` in cycles 1..41, `done` in cycle 41, `lines`=0, zero writes.
- Row 19 all 1s, cell (3,18)=5, rest 0 → `done` in cycle 641. RAM[193]=5, RAM[183]=0, RAM[190..199] otherwise 0, `lines`=1, 200 writes total.
- Rows 16..19 full (values 1..4), row 15 = pattern p → `lines`=4, row 19 = p, rows 0..18 empty, every write a single-cycle pulse.
- Only row 0 full → no shift, 10 CLR writes to addr 0..9 with data 0, `lines`=1.
- `resetn`=0 during SH_WR → next cycle IDLE, `ram_wren`=0, `busy`=0, `lines`=0. A new `start` runs a complete pass.
- `start` held high for the whole pass plus 2 cycles → exactly one `done` per IDLE entry, no restart while busy.

Source files
------------

// File: rtl/line_clear_ctrl_pkg.sv
// Shared tetris constants and the line-clear sequencer state encoding.
package line_clear_ctrl_pkg;
    localparam int BOARD_W = 10;
    localparam int BOARD_H = 20;
    localparam int CELL_W  = 6;
    localparam int ADDR_W  = 8;
    localparam logic [CELL_W-1:0] EMPTY_CELL = '0;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SCAN_A,
        ST_SCAN_W,
        ST_SH_A,
        ST_SH_W,
        ST_SH_WR,
        ST_CLR,
        ST_DONE
    } lcc_state_e;
endpackage

// File: rtl/line_clear_ctrl_if.sv
// Board RAM port plus start/status handshake of the line-clear sequencer.
interface line_clear_ctrl_if;
    import line_clear_ctrl_pkg::*;

    logic              start;
    logic [ADDR_W-1:0] ram_addr;
    logic              ram_wren;
    logic [CELL_W-1:0] ram_data;
    logic [CELL_W-1:0] ram_q;
    logic              busy;
    logic              done;
    logic [2:0]        lines;

    modport master (
        input  start, ram_q,
        output ram_addr, ram_wren, ram_data, busy, done, lines
    );
    modport slave (
        output start, ram_q,
        input  ram_addr, ram_wren, ram_data, busy, done, lines
    );
endinterface

// File: rtl/line_clear_ctrl_coord_to_addr.sv
// Board coordinate to linear RAM address: y*W + x.
module coord_to_addr #(
    parameter int W  = 10,
    parameter int XW = 4,
    parameter int YW = 5,
    parameter int AW = 8
) (
    input  logic [XW-1:0] x_i,
    input  logic [YW-1:0] y_i,
    output logic [AW-1:0] addr_o
);
    assign addr_o = AW'(y_i) * AW'(W) + AW'(x_i);
endmodule

// File: rtl/line_clear_ctrl.sv
// Scans the board bottom-up for full rows, shifts everything above each one
// down a row, clears the top row and counts the lines removed.
module line_clear_ctrl #(
    parameter int BOARD_W = 10,
    parameter int BOARD_H = 20,
    parameter int CELL_W  = 6
) (
    input  logic clk,
    input  logic resetn,
    line_clear_ctrl_if.master bus
);
    import line_clear_ctrl_pkg::*;

    localparam int XW = $clog2(BOARD_W);
    localparam int YW = $clog2(BOARD_H);
    localparam logic [XW-1:0] X_LAST = XW'(BOARD_W - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(BOARD_H - 1);
    localparam logic [YW-1:0] Y_ONE  = YW'(1);

    lcc_state_e        state_q, state_d;
    logic [XW-1:0]     x_q, x_d;
    logic [YW-1:0]     y_q, y_d;
    logic [YW-1:0]     r_q, r_d;
    logic [CELL_W-1:0] cell_q, cell_d;
    logic [2:0]        lines_q, lines_d;

    logic [XW-1:0]     addr_x;
    logic [YW-1:0]     addr_y;
    logic              wren;
    logic [CELL_W-1:0] wdata;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q <= ST_IDLE;
            x_q     <= '0;
            y_q     <= '0;
            r_q     <= '0;
            cell_q  <= '0;
            lines_q <= '0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            r_q     <= r_d;
            cell_q  <= cell_d;
            lines_q <= lines_d;
        end
    end

    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        r_d     = r_q;
        cell_d  = cell_q;
        lines_d = lines_q;
        addr_x  = '0;
        addr_y  = '0;
        wren    = 1'b0;
        wdata   = EMPTY_CELL;
        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    y_d     = Y_LAST;
                    x_d     = '0;
                    lines_d = '0;
                    state_d = ST_SCAN_A;
                end
            end
            ST_SCAN_A: begin
                addr_x  = x_q;
                addr_y  = y_q;
                state_d = ST_SCAN_W;
            end
            ST_SCAN_W: begin
                if (bus.ram_q == EMPTY_CELL) begin
                    if (y_q == '0) begin
                        state_d = ST_DONE;
                    end else begin
                        y_d     = y_q - Y_ONE;
                        x_d     = '0;
                        state_d = ST_SCAN_A;
                    end
                end else if (x_q != X_LAST) begin
                    x_d     = x_q + XW'(1);
                    state_d = ST_SCAN_A;
                end else begin
                    lines_d = (lines_q == 3'd7) ? lines_q : lines_q + 3'd1;
                    r_d     = y_q;
                    x_d     = '0;
                    state_d = (y_q == '0) ? ST_CLR : ST_SH_A;
                end
            end
            ST_SH_A: begin
                addr_x  = x_q;
                addr_y  = r_q - Y_ONE;
                state_d = ST_SH_W;
            end
            ST_SH_W: begin
                cell_d  = bus.ram_q;
                state_d = ST_SH_WR;
            end
            ST_SH_WR: begin
                addr_x = x_q;
                addr_y = r_q;
                wren   = 1'b1;
                wdata  = cell_q;
                if (x_q == X_LAST) begin
                    x_d     = '0;
                    r_d     = r_q - Y_ONE;
                    state_d = (r_q == Y_ONE) ? ST_CLR : ST_SH_A;
                end else begin
                    x_d     = x_q + XW'(1);
                    state_d = ST_SH_A;
                end
            end
            ST_CLR: begin
                // y is left alone so the row that just dropped in gets rescanned
                addr_x = x_q;
                addr_y = '0;
                wren   = 1'b1;
                if (x_q == X_LAST) begin
                    x_d     = '0;
                    state_d = ST_SCAN_A;
                end else begin
                    x_d = x_q + XW'(1);
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    coord_to_addr #(
        .W (BOARD_W),
        .XW(XW),
        .YW(YW),
        .AW(ADDR_W)
    ) u_addr (
        .x_i   (addr_x),
        .y_i   (addr_y),
        .addr_o(bus.ram_addr)
    );

    assign bus.ram_wren = wren;
    assign bus.ram_data = wdata;
    assign bus.busy     = (state_q != ST_IDLE);
    assign bus.done     = (state_q == ST_DONE);
    assign bus.lines    = lines_q;
endmodule

// File: tb/tb_line_clear_ctrl.sv
// Randomized and directed scoreboard bench for line_clear_ctrl with a row-level board model.
module tb_line_clear_ctrl;
    import line_clear_ctrl_pkg::*;

    localparam int NCELL = BOARD_W * BOARD_H;

    typedef logic [NCELL-1:0][CELL_W-1:0] board_t;
    typedef struct packed {
        logic [2:0]  lines;
        logic [31:0] cyc;
        logic [31:0] wr;
        board_t      b;
    } exp_t;

    logic clk = 1'b0;
    logic resetn;
    always #5 clk = ~clk;

    line_clear_ctrl_if bus();
    line_clear_ctrl dut (.clk(clk), .resetn(resetn), .bus(bus));

    logic [CELL_W-1:0] mem [0:255];
    board_t ld_b;
    logic   ld_go = 1'b0;

    always @(posedge clk) begin
        if (ld_go) begin
            for (int i = 0; i < NCELL; i++) mem[i] <= ld_b[i];
            for (int i = NCELL; i < 256; i++) mem[i] <= '0;
        end else if (bus.ram_wren) begin
            mem[bus.ram_addr] <= bus.ram_data;
        end
        bus.ram_q <= mem[bus.ram_addr];
    end

    int checks = 0, failures = 0;
    int cyc = 0, t0 = 0, wr_cnt = 0, n_done = 0;
    exp_t exp_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input int act, input int expv);
        checks++;
        if (act != expv) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", nm, act, expv);
        end
    endtask

    // Higher-level reference: repeatedly drop full rows, charging the documented cycle costs.
    function automatic exp_t model(input board_t b0);
        exp_t m;
        board_t b;
        int y, k, c, wr, nl;
        b = b0; y = BOARD_H - 1; c = 0; wr = 0; nl = 0;
        while (1) begin
            k = 0;
            while (k < BOARD_W && b[y*BOARD_W+k] != 0) k++;
            if (k < BOARD_W) begin
                c += 2 * (k + 1);
                if (y == 0) break;
                y--;
            end else begin
                c += 2 * BOARD_W;
                nl++;
                for (int rr = y; rr > 0; rr--)
                    for (int x = 0; x < BOARD_W; x++) b[rr*BOARD_W+x] = b[(rr-1)*BOARD_W+x];
                for (int x = 0; x < BOARD_W; x++) b[x] = '0;
                c  += 3 * BOARD_W * y + BOARD_W;
                wr += BOARD_W * y + BOARD_W;
            end
        end
        m.lines = (nl > 7) ? 3'd7 : 3'(nl);
        m.cyc   = 32'(c + 1);
        m.wr    = 32'(wr);
        m.b     = b;
        return m;
    endfunction

    logic             prev_busy = 1'b0, prev_wren = 1'b0;
    logic [ADDR_W-1:0] prev_addr = '0;

    always @(negedge clk) begin : monitor
        exp_t e;
        int bad;
        if (resetn === 1'b1) begin
            if (bus.busy && !prev_busy) begin
                t0 = cyc;
                wr_cnt = 0;
            end
            if (bus.ram_wren) begin
                wr_cnt++;
                checks++;
                if (!bus.busy || bus.ram_addr >= ADDR_W'(NCELL) ||
                    (prev_wren && prev_addr == bus.ram_addr)) begin
                    failures++;
                    $display("FAIL wr_pulse addr=%0d busy=%0b prev_wren=%0b", bus.ram_addr, bus.busy, prev_wren);
                end
            end
            if (bus.done) begin
                n_done++;
                if (exp_q.size() == 0) begin
                    chk("unexpected_done", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("lines", int'(bus.lines), int'(e.lines));
                    chk("done_cycle", cyc - t0 + 1, int'(e.cyc));
                    chk("write_count", wr_cnt, int'(e.wr));
                    bad = 0;
                    for (int i = 0; i < NCELL; i++) if (mem[i] != e.b[i]) bad++;
                    chk("board_bad_cells", bad, 0);
                end
            end
        end
        prev_busy = bus.busy;
        prev_wren = bus.ram_wren;
        prev_addr = bus.ram_addr;
    end

    task automatic load(input board_t b);
        @(negedge clk);
        ld_b  = b;
        ld_go = 1'b1;
        @(negedge clk);
        ld_go = 1'b0;
    endtask

    task automatic wait_done(input int target, input string nm);
        int t = 0;
        while (n_done < target && t < 30000) begin
            @(negedge clk);
            t++;
        end
        if (n_done < target) chk({nm, "_timeout"}, n_done, target);
    endtask

    task automatic run_pass(input board_t b, input string nm);
        exp_t e;
        int n0;
        load(b);
        e = model(b);
        exp_q.push_back(e);
        n0 = n_done;
        @(negedge clk);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        wait_done(n0 + 1, nm);
        repeat (2) @(negedge clk);
        chk({nm, "_lines_held"}, int'(bus.lines), int'(e.lines));
        chk({nm, "_idle_busy"}, int'(bus.busy), 0);
    endtask

    function automatic board_t fill_row(input board_t b, input int y, input logic [CELL_W-1:0] v);
        board_t r = b;
        for (int x = 0; x < BOARD_W; x++) r[y*BOARD_W+x] = v;
        return r;
    endfunction

    function automatic board_t rand_board();
        board_t b = '0;
        int mode, hole;
        for (int y = 0; y < BOARD_H; y++) begin
            mode = int'($urandom_range(0, 3));
            hole = int'($urandom_range(0, BOARD_W - 1));
            for (int x = 0; x < BOARD_W; x++) begin
                case (mode)
                    1: b[y*BOARD_W+x] = CELL_W'($urandom_range(1, 63));
                    2: b[y*BOARD_W+x] = (x == hole) ? '0 : CELL_W'($urandom_range(1, 63));
                    3: b[y*BOARD_W+x] = CELL_W'($urandom_range(0, 3));
                    default: b[y*BOARD_W+x] = '0;
                endcase
            end
        end
        return b;
    endfunction

    initial begin
        board_t b;
        exp_t e;
        int n0, t;

        resetn = 1'b0;
        bus.start = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_busy", int'(bus.busy), 0);
        chk("rst_wren", int'(bus.ram_wren), 0);
        chk("rst_done", int'(bus.done), 0);
        chk("rst_lines", int'(bus.lines), 0);
        chk("rst_addr", int'(bus.ram_addr), 0);
        chk("rst_data", int'(bus.ram_data), 0);
        resetn = 1'b1;

        run_pass('0, "empty");

        b = fill_row('0, 19, 6'd1);
        b[18*BOARD_W+3] = 6'd5;
        run_pass(b, "row19");

        b = '0;
        for (int y = 16; y < 20; y++) b = fill_row(b, y, CELL_W'(y - 15));
        for (int x = 0; x < BOARD_W; x++) b[15*BOARD_W+x] = (x % 3 == 0) ? '0 : CELL_W'(x + 7);
        run_pass(b, "four_rows");

        run_pass(fill_row('0, 0, 6'd9), "row0");

        b = '0;
        for (int y = 11; y < 20; y++) b = fill_row(b, y, CELL_W'(y));
        run_pass(b, "saturate");

        for (int i = 0; i < 6; i++) run_pass(rand_board(), "random");

        // start held through a whole pass: one restart from IDLE only
        load('0);
        e = model('0);
        exp_q.push_back(e);
        exp_q.push_back(e);
        n0 = n_done;
        @(negedge clk);
        bus.start = 1'b1;
        wait_done(n0 + 1, "held1");
        repeat (2) @(negedge clk);
        bus.start = 1'b0;
        wait_done(n0 + 2, "held2");
        repeat (6) @(negedge clk);
        chk("held_done_count", n_done - n0, 2);
        chk("held_idle", int'(bus.busy), 0);

        // reset during the first shift write
        b = fill_row('0, 19, 6'd3);
        b[17*BOARD_W+1] = 6'd7;
        load(b);
        exp_q.push_back(model(b));
        @(negedge clk);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        t = 0;
        while (!bus.ram_wren && t < 2000) begin
            @(negedge clk);
            t++;
        end
        chk("pre_reset_wren", int'(bus.ram_wren), 1);
        chk("pre_reset_lines", int'(bus.lines), 1);
        resetn = 1'b0;
        @(negedge clk);
        exp_q.delete();
        chk("mid_rst_wren", int'(bus.ram_wren), 0);
        chk("mid_rst_busy", int'(bus.busy), 0);
        chk("mid_rst_lines", int'(bus.lines), 0);
        chk("mid_rst_done", int'(bus.done), 0);
        resetn = 1'b1;
        run_pass(b, "after_reset");

        chk("queue_empty", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
